// File: rtl/mock_ram.sv
// mock_ram: byte-wide 256-entry responder RAM on the CPU memory bus.
// CPU accesses are qualified by a rising edge of the shared slave clock clk_in,
// detected in the clk_qzt domain. A loader port streams a program image into
// memory while the CPU bus is not serviced.
// Optional feature macro: MOCK_RAM_CLEAR_EN -- zero-fills all of memory after reset.
module mock_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_qzt,
  input  logic              reset,
  input  logic              en,
  input  logic              clk_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              write_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] dbg_ptr
);

`ifdef MOCK_RAM_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CLEAR} state_t;
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD} state_t;
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t              state;
  logic                clk_in_old;
  logic                step;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  assign step     = en & clk_in & ~clk_in_old;
  assign ld_ready = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign dbg_ptr  = ptr;

  // Single memory write port: CPU write in IDLE, loader byte in LOAD, zero in CLEAR.
  // Reset masks every write so an aborted load/clear stops on the reset cycle.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr;
    mem_wd = wr_data;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          // A step coinciding with ld_start is dropped entirely.
          if (!ld_start && step && write_en) begin
            mem_we = 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            mem_we = 1'b1;
            mem_wa = ptr;
            mem_wd = ld_byte;
          end
        end
`ifdef MOCK_RAM_CLEAR_EN
        ST_CLEAR: begin
          mem_we = 1'b1;
          mem_wa = ptr;
          mem_wd = '0;
        end
`endif
        default: ;
      endcase
    end
  end

  // Storage array; contents are never touched by reset directly.
  always_ff @(posedge clk_qzt) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Control FSM: step edge tracking, read data register, load/clear pointer.
  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      state      <= RESET_STATE;
      clk_in_old <= 1'b0;
      rd_data    <= '0;
      ptr        <= '0;
    end else begin
      clk_in_old <= clk_in;
      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            state <= ST_LOAD;
            ptr   <= ld_addr;
          end else if (step) begin
            // Read-before-write: the old contents are returned on a write step.
            rd_data <= mem[addr];
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            ptr <= ptr + ADDR_W'(1);
            if (ld_last) begin
              state <= ST_IDLE;
            end
          end
        end
`ifdef MOCK_RAM_CLEAR_EN
        ST_CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == '1) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mock_ram.sv
// Self-checking bench for mock_ram: randomized CPU steps and loader bursts
// checked against an array model of memory plus a model of the read register.
module tb_mock_ram;

  logic       clk_qzt = 1'b0;
  logic       reset;
  logic       en;
  logic       clk_in;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       write_en;
  logic [7:0] rd_data;
  logic       ld_start;
  logic [7:0] ld_addr;
  logic       ld_valid;
  logic [7:0] ld_byte;
  logic       ld_last;
  logic       ld_ready;
  logic       busy;
  logic [7:0] dbg_ptr;

  mock_ram #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk_qzt (clk_qzt),
    .reset   (reset),
    .en      (en),
    .clk_in  (clk_in),
    .addr    (addr),
    .wr_data (wr_data),
    .write_en(write_en),
    .rd_data (rd_data),
    .ld_start(ld_start),
    .ld_addr (ld_addr),
    .ld_valid(ld_valid),
    .ld_byte (ld_byte),
    .ld_last (ld_last),
    .ld_ready(ld_ready),
    .busy    (busy),
    .dbg_ptr (dbg_ptr)
  );

  always #5 clk_qzt = ~clk_qzt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] mem_m [256];
  logic [7:0] rd_m;
  logic [7:0] ld_q [$];

  task automatic tick;
    @(posedge clk_qzt);
    #1;
  endtask

  // One CPU step: inputs present before the clk_in rising edge; clk_in held
  // high for 'hold' cycles while addr/wr_data wander (must not re-trigger).
  task automatic do_step(input logic [7:0] a, input logic [7:0] d, input logic w,
                         input logic e, input int unsigned hold);
    en = e; addr = a; wr_data = d; write_en = w; clk_in = 1'b1;
    tick;
    if (e) begin
      rd_m = mem_m[a];
      if (w) mem_m[a] = d;
    end
    for (int unsigned i = 1; i < hold; i++) begin
      addr = 8'($urandom); wr_data = 8'($urandom);
      tick;
    end
    clk_in = 1'b0; write_en = 1'b0; en = 1'b1;
    tick;
  endtask

  // Stream ld_q starting at 'start'; gaps carry ignored CPU write steps.
  task automatic do_load(input logic [7:0] start);
    logic [7:0] p;
    ld_start = 1'b1; ld_addr = start;
    tick;
    ld_start = 1'b0; ld_addr = 8'($urandom);
    n_cmp++;
    if (ld_ready !== 1'b1 || busy !== 1'b1 || dbg_ptr !== start) begin
      n_err++;
      $display("FAIL load_enter: ready=%b busy=%b ptr=%h, want 1 1 %h", ld_ready, busy, dbg_ptr, start);
    end
    p = start;
    for (int i = 0; i < ld_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        addr = 8'($urandom); wr_data = 8'($urandom); write_en = 1'b1; clk_in = 1'b1;
        tick;
        clk_in = 1'b0; write_en = 1'b0;
      end
      ld_valid = 1'b1; ld_byte = ld_q[i]; ld_last = (i == ld_q.size() - 1);
      tick;
      mem_m[p] = ld_q[i];
      p = p + 8'd1;
      ld_valid = 1'b0; ld_last = 1'b0;
      if (i != ld_q.size() - 1) begin
        n_cmp++;
        if (dbg_ptr !== p || ld_ready !== 1'b1) begin
          n_err++;
          $display("FAIL load_ptr: ptr=%h ready=%b, want %h 1", dbg_ptr, ld_ready, p);
        end
      end
    end
    n_cmp++;
    if (ld_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_exit: ready=%b busy=%b, want 0 0", ld_ready, busy);
    end
  endtask

`ifdef MOCK_RAM_CLEAR_EN
  // Call right after the reset edge; counts busy cycles, injecting a CPU write late in the clear.
  task automatic wait_clear;
    int unsigned cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      if (cnt == 250) begin addr = 8'h05; wr_data = 8'hAA; write_en = 1'b1; clk_in = 1'b1; end
      if (cnt == 251) begin clk_in = 1'b0; write_en = 1'b0; end
      if (cnt == 252) begin ld_start = 1'b1; ld_addr = 8'h09; end
      if (cnt == 253) ld_start = 1'b0;
      cnt++;
      tick;
    end
    clk_in = 1'b0; write_en = 1'b0; ld_start = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    n_cmp++;
    if (cnt != 256) begin
      n_err++;
      $display("FAIL clear_len: busy cycles=%0d, want 256", cnt);
    end
  endtask
`endif

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    n_cmp++;
`ifdef MOCK_RAM_CLEAR_EN
    if (rd_data !== 8'h00 || ld_ready !== 1'b0 || dbg_ptr !== 8'h00 || busy !== 1'b1) begin
`else
    if (rd_data !== 8'h00 || ld_ready !== 1'b0 || dbg_ptr !== 8'h00 || busy !== 1'b0) begin
`endif
      n_err++;
      $display("FAIL reset_state: rd=%h ready=%b ptr=%h busy=%b", rd_data, ld_ready, dbg_ptr, busy);
    end
    reset = 1'b0;
    rd_m = 8'h00;
`ifdef MOCK_RAM_CLEAR_EN
    wait_clear;
`endif
  endtask

  task automatic test_fill;
    logic [7:0] s;
    ld_q.delete();
    for (int i = 0; i < 256; i++) ld_q.push_back(8'($urandom));
    s = 8'($urandom);
    do_load(s);
  endtask

  task automatic test_readback;
    for (int i = 0; i < 256; i++) begin
      do_step(8'(i), 8'h00, 1'b0, 1'b1, 1);
      n_cmp++;
      if (rd_data !== rd_m) begin
        n_err++;
        $display("FAIL readback[%h]: got %h want %h", i, rd_data, rd_m);
      end
    end
  endtask

  task automatic test_read;
    ld_q.delete();
    ld_q.push_back(8'hC3);
    do_load(8'h10);
    do_step(8'h10, 8'h00, 1'b0, 1'b1, 1);
    n_cmp++;
    if (rd_data !== 8'hC3) begin
      n_err++;
      $display("FAIL read_c3: got %h want c3", rd_data);
    end
    addr = 8'h11;
    repeat (5) tick;
    n_cmp++;
    if (rd_data !== 8'hC3) begin
      n_err++;
      $display("FAIL read_hold: got %h want c3", rd_data);
    end
  endtask

  task automatic test_write;
    logic [7:0] a;
    do_step(8'h20, 8'h5A, 1'b1, 1'b1, 1);
    do_step(8'h20, 8'hFF, 1'b0, 1'b1, 1);
    n_cmp++;
    if (rd_data !== 8'h5A) begin
      n_err++;
      $display("FAIL write_b2b: got %h want 5a", rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      a = 8'h1F + 8'(i);
      do_step(a, 8'h00, 1'b0, 1'b1, 1);
      n_cmp++;
      if (rd_data !== rd_m || (a == 8'h20 && rd_data !== 8'h5A)) begin
        n_err++;
        $display("FAIL write_nbr[%h]: got %h want %h", a, rd_data, rd_m);
      end
    end
  endtask

  task automatic test_random_steps;
    for (int i = 0; i < 120; i++) begin
      do_step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) != 0), $urandom_range(1, 3));
      n_cmp++;
      if (rd_data !== rd_m) begin
        n_err++;
        $display("FAIL rand_step[%0d]: got %h want %h", i, rd_data, rd_m);
      end
      repeat ($urandom_range(0, 2)) tick;
    end
  endtask

  task automatic test_load_wrap;
    ld_q.delete();
    ld_q.push_back(8'h11); ld_q.push_back(8'h22); ld_q.push_back(8'h33);
    do_load(8'hFE);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] a;
      a = 8'hFE + 8'(i);
      do_step(a, 8'h00, 1'b0, 1'b1, 1);
      n_cmp++;
      if (rd_data !== ld_q[i]) begin
        n_err++;
        $display("FAIL load_wrap[%h]: got %h want %h", a, rd_data, ld_q[i]);
      end
    end
  endtask

  task automatic test_collision;
    logic [7:0] rd_before;
    do_step(8'h41, 8'h00, 1'b0, 1'b1, 1);
    rd_before = rd_m;
    en = 1'b1; addr = 8'h40; wr_data = 8'hEE; write_en = 1'b1; clk_in = 1'b1;
    ld_start = 1'b1; ld_addr = 8'h40;
    tick;
    ld_start = 1'b0; clk_in = 1'b0; write_en = 1'b0;
    n_cmp++;
    if (rd_data !== rd_before || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL collide_drop: rd=%h ready=%b, want %h 1", rd_data, ld_ready, rd_before);
    end
    tick;
    ld_valid = 1'b1; ld_byte = 8'h77; ld_last = 1'b1;
    tick;
    mem_m[8'h40] = 8'h77;
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || rd_data !== rd_before) begin
      n_err++;
      $display("FAIL collide_exit: busy=%b rd=%h, want 0 %h", busy, rd_data, rd_before);
    end
    do_step(8'h40, 8'h00, 1'b0, 1'b1, 1);
    n_cmp++;
    if (rd_data !== 8'h77) begin
      n_err++;
      $display("FAIL collide_mem: got %h want 77", rd_data);
    end
  endtask

  task automatic test_reset_during_load;
    logic [7:0] s;
    s = 8'($urandom);
    ld_start = 1'b1; ld_addr = s;
    tick;
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_byte = 8'($urandom); ld_last = 1'b0;
      tick;
      mem_m[s + 8'(i)] = ld_byte;
    end
    // Third byte is offered on the reset cycle and must not land.
    ld_byte = ~mem_m[s + 8'd2];
    reset = 1'b1;
    tick;
    reset = 1'b0; ld_valid = 1'b0;
    rd_m = 8'h00;
    n_cmp++;
    if (ld_ready !== 1'b0 || rd_data !== 8'h00 || dbg_ptr !== 8'h00) begin
      n_err++;
      $display("FAIL rst_load_state: ready=%b rd=%h ptr=%h, want 0 00 00", ld_ready, rd_data, dbg_ptr);
    end
`ifdef MOCK_RAM_CLEAR_EN
    wait_clear;
`else
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_load_busy: got %b want 0", busy);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = s + 8'(i);
      do_step(a, 8'h00, 1'b0, 1'b1, 1);
      n_cmp++;
      if (rd_data !== rd_m) begin
        n_err++;
        $display("FAIL rst_load_mem[%h]: got %h want %h", a, rd_data, rd_m);
      end
    end
  endtask

`ifdef MOCK_RAM_CLEAR_EN
  task automatic test_clear;
    ld_q.delete();
    for (int i = 0; i < 256; i++) ld_q.push_back(8'hFF);
    do_load(8'h00);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    rd_m = 8'h00;
    wait_clear;
    test_readback;
  endtask
`endif

  initial begin
    reset = 1'b1; en = 1'b1; clk_in = 1'b0; addr = '0; wr_data = '0; write_en = 1'b0;
    ld_start = 1'b0; ld_addr = '0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    rd_m = 8'h00;
    test_reset;
    test_fill;
    test_readback;
    test_read;
    test_write;
    test_random_steps;
    test_load_wrap;
    test_collision;
    test_reset_during_load;
`ifdef MOCK_RAM_CLEAR_EN
    test_clear;
`endif
    test_random_steps;
    test_readback;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
